seven_seg_driver: RTL and testbench
===================================

SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 17, width of the free-running digit-scan counter; digit period is 2^(REFRESH_DIV-2) clocks.
REQ-002 SHALL have parameter NUM_SHIFTS, default 8, the number of double-dabble shift cycles; fixed to the 8-bit input width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all flops on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port value, input, 8, the result byte from the subtractor/complement stage.
REQ-006 SHALL have port signed_mode, input, 1; 1 interprets value as two's complement, 0 as unsigned.
REQ-007 SHALL have port seg, output, 7, active-low cathodes, seg[6:0] = g,f,e,d,c,b,a.
REQ-008 SHALL have port dp, output, 1, active-low decimal point.
REQ-009 SHALL have port an, output, 4, active-low one-hot anodes, an[3] is the leftmost digit.
REQ-010 SHALL have port busy, output, 1, high while a conversion is in progress.

Function
REQ-011 SHALL register value and signed_mode into a sample register every clock.
REQ-012 SHALL have FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE -> SHIFT when sample differs from the last-converted snapshot or the snapshot-valid flag is 0; snapshot is taken, shift counter cleared, busy = 1.
REQ-014 Magnitude on start: signed_mode=1 with value[7]=1 -> 8-bit two's-complement negation, neg=1 (8'h80 -> 128); otherwise magnitude = value, neg=0.
REQ-015 SHIFT SHALL run exactly 8 cycles: add 3 to each BCD nibble >= 5, then shift left one bit; SHIFT -> DONE after the 8th.
REQ-016 DONE SHALL latch hundreds, tens, ones and neg into the display registers, set snapshot-valid, go to IDLE and drop busy; busy is high for exactly 10 cycles.
REQ-017 Input changes during SHIFT/DONE SHALL be ignored; they are re-checked in IDLE against the snapshot, so the display always converges to the stable input.
REQ-018 Display registers SHALL change only in DONE; no partial BCD is ever shown.
REQ-019 Scan counter SHALL be free-running; its top 2 bits select the digit 0..3 and wrap 3 -> 0.
REQ-020 Digit 3 SHALL show '-' (7'b0111111) when neg=1, else blank (7'b1111111).
REQ-021 Digits 2,1,0 SHALL show hundreds, tens, ones; hundreds blanked when 0; tens blanked when hundreds and tens are both 0; ones always shown.
REQ-022 dp SHALL be constant 1 (off).
REQ-023 Digit encodings 0-9 SHALL be the standard active-low patterns (0 = 7'b1000000, 8 = 7'b0000000).

Reset
REQ-024 reset SHALL act immediately, regardless of clk: an = 4'b1111, seg = 7'b1111111, dp = 1, busy = 0, FSM = IDLE.
REQ-025 reset SHALL clear the scan counter, sample, snapshot, shift register, display registers and snapshot-valid.
REQ-026 A conversion is forced on the first IDLE cycle after release, since snapshot-valid = 0.
REQ-027 reset asserted mid-conversion SHALL abandon it with no display update.

Structure
REQ-028 Package seg_pkg SHALL hold the FSM state enum, the segment constants for 0-9, minus and blank, and SEG_OFF/AN_OFF.
REQ-029 The sequential double-dabble (REQ-014..016 datapath) SHALL be sub-module bin_to_bcd, with start/busy/done handshake.
REQ-030 Scan counter, digit mux and blanking logic SHALL live in seven_seg_driver.

Verification (bench uses REFRESH_DIV=4)
REQ-031 Assert reset mid-scan between edges -> an=4'b1111, seg=7'b1111111, busy=0 without a clock edge; after release, display shows "   0".
REQ-032 signed_mode=0, value=8'hFF -> busy high 10 cycles; digits "255", an[3] blank; an cycles 1110,1101,1011,0111 every 4 clocks.
REQ-033 signed_mode=1, value=8'hF6 -> "- 10": '-', blank, '1', '0'.
REQ-034 signed_mode=1, value=8'h80 -> "-128"; same value with signed_mode=0 -> " 128" (mode toggle alone retriggers).
REQ-035 value 8'h05 then 8'h63 three cycles later (mid-SHIFT) -> display goes "   5", then "  99" after a second conversion; never an intermediate value.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble: byte (signed or unsigned) to sign + three BCD digits.
// Latency: start accepted in IDLE, NUM_SHIFTS SHIFT cycles, results valid with done in DONE.
// Backpressure: start is ignored while busy; the caller re-requests once idle.
module bin_to_bcd
    import seg_pkg::*;
#(
    parameter int NUM_SHIFTS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       signed_mode,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       neg
);

    localparam int CNT_W = $clog2(NUM_SHIFTS + 1);

    conv_state_t      state, state_nxt;
    logic [19:0]      shreg, shreg_nxt;   // {hundreds, tens, ones, binary}
    logic [19:0]      adj;
    logic [7:0]       mag;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             neg_q, neg_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            neg_q <= neg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        neg_nxt   = neg_q;
        busy      = 1'b0;
        done      = 1'b0;
        adj       = shreg;
        mag       = value;
        case (state)
            IDLE: begin
                if (start) begin
                    // 8'h80 negates to itself, which reads correctly as 128 unsigned
                    if (signed_mode && value[7]) begin
                        mag     = 8'd0 - value;
                        neg_nxt = 1'b1;
                    end else begin
                        mag     = value;
                        neg_nxt = 1'b0;
                    end
                    shreg_nxt = {12'd0, mag};
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (adj[8+4*i +: 4] >= 4'd5)
                        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
                end
                shreg_nxt = {adj[18:0], 1'b0};
                cnt_nxt   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(NUM_SHIFTS - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hundreds = shreg[19:16];
    assign tens     = shreg[15:12];
    assign ones     = shreg[11:8];
    assign neg      = neg_q;

endmodule

// File: rtl/seven_seg_driver.sv
// Shows a byte as signed or unsigned decimal on a 4-digit multiplexed active-low display.
// Latency: a new input is shown about 12 clocks after it settles (sample, 10-cycle busy, output flop).
// Backpressure: none; changes during a conversion are re-checked in idle so the display converges.
module seven_seg_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 17,
    parameter int NUM_SHIFTS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    logic [REFRESH_DIV-1:0] scan_cnt;
    logic [7:0]             value_s, snap_value;
    logic                   mode_s, snap_mode, snap_vld;
    logic                   req, start, conv_busy, conv_done;
    logic [3:0]             bcd_h, bcd_t, bcd_o;
    logic                   bcd_neg;
    logic [3:0]             disp_h, disp_t, disp_o;
    logic                   disp_neg;
    logic [1:0]             digit;
    logic [6:0]             seg_nxt;
    logic [3:0]             an_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_s    <= '0;
            mode_s     <= 1'b0;
            snap_value <= '0;
            snap_mode  <= 1'b0;
            snap_vld   <= 1'b0;
        end else begin
            value_s <= value;
            mode_s  <= signed_mode;
            if (start) begin
                snap_value <= value_s;
                snap_mode  <= mode_s;
            end
            if (conv_done)
                snap_vld <= 1'b1;
        end
    end

    assign req   = !snap_vld || (value_s != snap_value) || (mode_s != snap_mode);
    assign start = req && !conv_busy;
    // req is high throughout reset, so busy is gated to stay low then
    assign busy  = !reset && (conv_busy || req);

    bin_to_bcd #(
        .NUM_SHIFTS(NUM_SHIFTS)
    ) u_bin_to_bcd (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .value      (value_s),
        .signed_mode(mode_s),
        .busy       (conv_busy),
        .done       (conv_done),
        .hundreds   (bcd_h),
        .tens       (bcd_t),
        .ones       (bcd_o),
        .neg        (bcd_neg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_h   <= '0;
            disp_t   <= '0;
            disp_o   <= '0;
            disp_neg <= 1'b0;
        end else if (conv_done) begin
            disp_h   <= bcd_h;
            disp_t   <= bcd_t;
            disp_o   <= bcd_o;
            disp_neg <= bcd_neg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + REFRESH_DIV'(1);
    end

    assign digit = scan_cnt[REFRESH_DIV-1 -: 2];

    always_comb begin
        seg_nxt       = SEG_BLANK;
        an_nxt        = AN_OFF;
        an_nxt[digit] = 1'b0;
        case (digit)
            2'd3:    seg_nxt = disp_neg ? SEG_MINUS : SEG_BLANK;
            2'd2:    seg_nxt = (disp_h == 4'd0) ? SEG_BLANK : bcd_to_seg(disp_h);
            2'd1:    seg_nxt = (disp_h == 4'd0 && disp_t == 4'd0) ? SEG_BLANK : bcd_to_seg(disp_t);
            default: seg_nxt = bcd_to_seg(disp_o);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_driver.sv
// Bench for seven_seg_driver: table vectors, hand sequences for reset/retrigger, and
// random bytes checked against a decimal-string model.
module tb_seven_seg_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = 8'd0;
    logic       signed_mode = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] DIGIT_PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef struct {
        logic [7:0]  value;
        logic        mode;
        logic [31:0] exp;   // four ASCII chars, leftmost digit in the top byte
    } vec_t;

    vec_t vecs [14];

    seven_seg_driver #(
        .REFRESH_DIV(4),
        .NUM_SHIFTS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .signed_mode(signed_mode),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] char_seg(input logic [7:0] c);
        if (c == " ") return 7'b1111111;
        if (c == "-") return 7'b0111111;
        if (c >= "0" && c <= "9") return DIGIT_PAT[c - 8'd48];
        return 7'b1010101;
    endfunction

    function automatic logic [31:0] model(input logic [7:0] v, input logic m);
        int  mag, h, t, o;
        logic [7:0] c3, c2, c1, c0;
        mag = (m && v >= 8'd128) ? 256 - int'(v) : int'(v);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        c3 = (m && v >= 8'd128) ? "-" : " ";
        c2 = (h != 0) ? 8'(48 + h) : " ";
        c1 = (h != 0 || t != 0) ? 8'(48 + t) : " ";
        c0 = 8'(48 + o);
        return {c3, c2, c1, c0};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_busy_clear"}, 32'(busy), 32'(1'b0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_display(input string name, input logic [31:0] exp);
        logic [6:0] got [4];
        bit seen [4];
        bit bad [4];
        bit bad_an, bad_dp;
        int d;
        bad_an = 0;
        bad_dp = 0;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 0;
            bad[i]  = 0;
            got[i]  = 7'b1111111;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            if (d < 0) begin
                bad_an = 1;
            end else begin
                if (!seen[d] || seg != char_seg(exp[d*8 +: 8])) got[d] = seg;
                seen[d] = 1;
                if (seg != char_seg(exp[d*8 +: 8])) bad[d] = 1;
            end
            if (dp !== 1'b1) bad_dp = 1;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!seen[i] || bad[i]) begin
                errors++;
                $display("FAIL %s digit%0d: seg=%b seen=%0d required %b for \"%s\"",
                         name, i, got[i], seen[i], char_seg(exp[i*8 +: 8]), exp);
            end
        end
        checks++;
        if (bad_an || bad_dp) begin
            errors++;
            $display("FAIL %s an/dp: an_onehot_ok=%0d dp_ok=%0d required 1 and 1",
                     name, !bad_an, !bad_dp);
        end
    endtask

    task automatic apply(input string name, input logic [7:0] v, input logic m, input logic [31:0] exp);
        @(negedge clk);
        value       = v;
        signed_mode = m;
        wait_idle(name);
        check_display(name, exp);
    endtask

    task automatic check_scan(input string name);
        logic [3:0] prev;
        int  k;
        bit  bad;
        logic [3:0] bad_an, want_an;
        k = 0;
        bad = 0;
        bad_an = 4'd0;
        want_an = 4'd0;
        prev = an;
        @(negedge clk);
        while (!(an == 4'b1110 && prev == 4'b0111) && k < 40) begin
            prev = an;
            @(negedge clk);
            k++;
        end
        check_eq({name, "_sync"}, 32'(an), 32'(4'b1110));
        for (int i = 0; i < 16; i++) begin
            if (an != ~(4'b0001 << (i / 4)) && !bad) begin
                bad     = 1;
                bad_an  = an;
                want_an = ~(4'b0001 << (i / 4));
            end
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: an=%b required %b", name, bad_an, want_an);
        end
    endtask

    task automatic measure_busy(output int n);
        int k;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  nbusy;
        bit  bad_mix;
        logic [7:0] rv;
        logic       rm;

        vecs[0]  = '{8'hF6, 1'b1, "- 10"};
        vecs[1]  = '{8'h80, 1'b1, "-128"};
        vecs[2]  = '{8'h80, 1'b0, " 128"};
        vecs[3]  = '{8'h05, 1'b0, "   5"};
        vecs[4]  = '{8'h63, 1'b0, "  99"};
        vecs[5]  = '{8'h00, 1'b1, "   0"};
        vecs[6]  = '{8'hFF, 1'b1, "-  1"};
        vecs[7]  = '{8'h7F, 1'b1, " 127"};
        vecs[8]  = '{8'h64, 1'b0, " 100"};
        vecs[9]  = '{8'h0A, 1'b0, "  10"};
        vecs[10] = '{8'h9C, 1'b1, "-100"};
        vecs[11] = '{8'h81, 1'b1, "-127"};
        vecs[12] = '{8'h7F, 1'b0, " 127"};
        vecs[13] = '{8'hFF, 1'b0, " 255"};

        // Reset state, before any clock edge
        #1 reset = 1'b1;
        #1;
        check_eq("rst_an",   32'(an),   32'(4'b1111));
        check_eq("rst_seg",  32'(seg),  32'(7'b1111111));
        check_eq("rst_dp",   32'(dp),   32'(1'b1));
        check_eq("rst_busy", 32'(busy), 32'(1'b0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_idle("post_reset");
        check_display("post_reset", "   0");

        // 0xFF unsigned: 10-cycle busy, " 255", scan order
        @(negedge clk);
        value       = 8'hFF;
        signed_mode = 1'b0;
        measure_busy(nbusy);
        check_eq("ff_busy_len", 32'(nbusy), 32'd10);
        repeat (2) @(negedge clk);
        check_display("ff_unsigned", " 255");
        check_scan("scan_order");

        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), vecs[i].value, vecs[i].mode, vecs[i].exp);

        // Reset mid-conversion, between clock edges
        @(negedge clk);
        value       = 8'h10;
        signed_mode = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_an",   32'(an),   32'(4'b1111));
        check_eq("mid_rst_seg",  32'(seg),  32'(7'b1111111));
        check_eq("mid_rst_busy", 32'(busy), 32'(1'b0));
        value = 8'h00;
        @(negedge clk);
        #3 reset = 1'b0;
        wait_idle("mid_rst_release");
        check_display("mid_rst_release", "   0");

        // Input change mid-SHIFT: back-to-back conversions, no intermediate digits
        @(negedge clk);
        value   = 8'h05;
        nbusy   = 0;
        bad_mix = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 3) value = 8'h63;
            if (busy) nbusy++;
            case (an)
                4'b1110: if (seg != char_seg("0") && seg != char_seg("5") && seg != char_seg("9")) bad_mix = 1;
                4'b1101: if (seg != char_seg(" ") && seg != char_seg("9")) bad_mix = 1;
                4'b1011: if (seg != char_seg(" ")) bad_mix = 1;
                4'b0111: if (seg != char_seg(" ")) bad_mix = 1;
                default: bad_mix = 1;
            endcase
        end
        check_eq("retrig_busy_len", 32'(nbusy), 32'd20);
        check_eq("retrig_no_partial", 32'(bad_mix), 32'(1'b0));
        check_display("retrig_final", "  99");

        // Random bytes against the decimal model
        for (int i = 0; i < 16; i++) begin
            rv = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            apply($sformatf("rand%0d_%02h_%0d", i, rv, rm), rv, rm, model(rv, rm));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
